glb_rdport_arb: RTL
===================

Name: glb_rdport_arb

Overview:
- Shares one GLB read port (addr/data handshake pair) between NUM_REQ requesters, e.g. the pooling, FPS and conv engines.
- Each requester submits a burst command (base address and length). The arbiter grants one burst at a time in round-robin order.
- It generates the sequential address stream toward the GLB, tracks outstanding reads, and routes returned data to the granted requester.
- It sits between the engines and one GLB read port.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- ADDR_WIDTH, 16, GLB read address width.
- LEN_WIDTH, 16, burst length field width (number of words).
- DATA_WIDTH, 8192, read data width (SRAM_WIDTH*MAXPAR).
- MAX_OUTSTD, 4, maximum address handshakes awaiting data (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- REQARB_CmdAddr  in  NUM_REQ*ADDR_WIDTH  burst base address per requester
- REQARB_CmdLen  in  NUM_REQ*LEN_WIDTH  burst length in words per requester
- REQARB_CmdVld  in  NUM_REQ  command valid
- ARBREQ_CmdRdy  out  NUM_REQ  command accepted (one-hot or zero)
- ARBREQ_Dat  out  DATA_WIDTH  read data, broadcast to all requesters
- ARBREQ_DatVld  out  NUM_REQ  data valid, granted requester only
- REQARB_DatRdy  in  NUM_REQ  requester data ready
- ARBGLB_RdAddr  out  ADDR_WIDTH  GLB read address
- ARBGLB_RdAddrVld  out  1  GLB read address valid
- GLBARB_RdAddrRdy  in  1  GLB read address ready
- GLBARB_RdDat  in  DATA_WIDTH  GLB read data
- GLBARB_RdDatVld  in  1  GLB read data valid
- ARBGLB_RdDatRdy  out  1  ready toward GLB
- ARB_Busy  out  1  FSM not in IDLE
- ARB_GntIdx  out  $clog2(NUM_REQ)  index of the current or last grant
- ARB_Err  out  1  sticky protocol error

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-high (rst).
- Reset values: FSM=IDLE, rr_ptr=0, addr_cnt=0, outstd=0, ARB_GntIdx=0, ARB_Err=0.
  - All valid/ready outputs are 0 and ARBGLB_RdAddr=0.
  - Reset mid-burst aborts the burst. Any GLB data that arrives after reset is not routed and raises ARB_Err.
- FSM states:
  - IDLE:
    - Round-robin pick: the first REQARB_CmdVld at or after rr_ptr, searching upward and wrapping.
    - ARBREQ_CmdRdy[pick]=1 combinationally in the same cycle; this is the handshake cycle T.
    - Latch base, len and GntIdx. addr_cnt←0.
    - If len≠0, next state is ISSUE. If len=0, next state stays IDLE (null burst, no GLB traffic) and rr_ptr←pick+1.
  - ISSUE:
    - ARBGLB_RdAddrVld = (outstd<MAX_OUTSTD). Asserted first at T+1.
    - ARBGLB_RdAddr = base+addr_cnt, modulo 2^ADDR_WIDTH (wraps silently).
    - On an address handshake, addr_cnt++. When addr_cnt==len-1 on a handshake, go to DRAIN.
  - DRAIN:
    - No address issued.
    - When outstd==0, or outstd==1 with a data handshake this cycle, go to IDLE next cycle.
    - On leaving, rr_ptr←GntIdx+1 (mod NUM_REQ).
- Command rules: ARBREQ_CmdRdy is 0 outside IDLE. A requester must hold CmdVld/Addr/Len stable until CmdRdy.
- Outstanding counter:
  - Address handshake only: outstd+1. Data handshake only: outstd-1. Both in the same cycle: unchanged.
  - outstd never exceeds MAX_OUTSTD.
- Data path:
  - ARBREQ_Dat = GLBARB_RdDat, combinational.
  - ARBREQ_DatVld[GntIdx] = GLBARB_RdDatVld & (outstd≠0); all other bits 0.
  - ARBGLB_RdDatRdy = REQARB_DatRdy[GntIdx] & (outstd≠0) & (FSM≠IDLE).
  - Zero added latency; backpressure passes through unchanged.
- ARB_Err: set when GLBARB_RdDatVld=1 while outstd==0, or in IDLE. Cleared only by rst.
- The next grant can start in the cycle the FSM is back in IDLE. Minimum gap between bursts: 1 cycle (the IDLE cycle).

Test Plan:
- Single burst: req0 Addr=0x0010, Len=3, GLB always ready, data returned 1 cycle after each address.
  - Required: CmdRdy[0] at T.
  - Required: addresses 0x10, 0x11, 0x12 at T+1..T+3.
  - Required: 3 DatVld[0] pulses; ARB_Busy falls after the last data; rr_ptr=1.
- Round-robin: all four requesters hold CmdVld with Len=1.
  - Required: grants in order 0,1,2,3,0.
  - Required: DatVld never asserted on a non-granted bit.
- Outstanding cap: Len=8, GLB address always ready, GLB data withheld.
  - Required: exactly 4 address handshakes, then RdAddrVld=0.
  - Release one data word: exactly one more address issues.
- Backpressure and edge lengths:
  - REQARB_DatRdy[g]=0 for 5 cycles: ARBGLB_RdDatRdy=0 and outstd stays constant.
  - Len=0 command: CmdRdy pulse, no RdAddrVld, FSM stays IDLE.
  - Base=0xFFFE, Len=3: addresses 0xFFFE, 0xFFFF, 0x0000.
- Reset mid-burst: assert rst for 1 cycle during ISSUE with outstd=2.
  - Required next cycle: IDLE, all valids 0, outstd=0, rr_ptr=0.
  - Stray GLB data afterwards: ARB_Err=1 and stays 1 until the next rst.

Source files
------------

// File: rtl/glb_rdport_arb_if.sv
// Bus bundle between the requester engines, the GLB read port and the arbiter.
// The master modport is the arbiter's view; slave is the requester/GLB side.
interface glb_rdport_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int DATA_WIDTH = 8192
);
    logic [NUM_REQ*ADDR_WIDTH-1:0] REQARB_CmdAddr;
    logic [NUM_REQ*LEN_WIDTH-1:0]  REQARB_CmdLen;
    logic [NUM_REQ-1:0]            REQARB_CmdVld;
    logic [NUM_REQ-1:0]            ARBREQ_CmdRdy;
    logic [DATA_WIDTH-1:0]         ARBREQ_Dat;
    logic [NUM_REQ-1:0]            ARBREQ_DatVld;
    logic [NUM_REQ-1:0]            REQARB_DatRdy;
    logic [ADDR_WIDTH-1:0]         ARBGLB_RdAddr;
    logic                          ARBGLB_RdAddrVld;
    logic                          GLBARB_RdAddrRdy;
    logic [DATA_WIDTH-1:0]         GLBARB_RdDat;
    logic                          GLBARB_RdDatVld;
    logic                          ARBGLB_RdDatRdy;

    modport master (
        input  REQARB_CmdAddr, REQARB_CmdLen, REQARB_CmdVld, REQARB_DatRdy,
        input  GLBARB_RdAddrRdy, GLBARB_RdDat, GLBARB_RdDatVld,
        output ARBREQ_CmdRdy, ARBREQ_Dat, ARBREQ_DatVld,
        output ARBGLB_RdAddr, ARBGLB_RdAddrVld, ARBGLB_RdDatRdy
    );

    modport slave (
        output REQARB_CmdAddr, REQARB_CmdLen, REQARB_CmdVld, REQARB_DatRdy,
        output GLBARB_RdAddrRdy, GLBARB_RdDat, GLBARB_RdDatVld,
        input  ARBREQ_CmdRdy, ARBREQ_Dat, ARBREQ_DatVld,
        input  ARBGLB_RdAddr, ARBGLB_RdAddrVld, ARBGLB_RdDatRdy
    );
endinterface

// File: rtl/glb_rdport_arb.sv
// Round-robin burst arbiter sharing one GLB read port between NUM_REQ engines.
// Generates the address stream, caps outstanding reads and routes data back.
module glb_rdport_arb #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int DATA_WIDTH = 8192,
    parameter int MAX_OUTSTD = 4,
    localparam int IDX_W     = $clog2(NUM_REQ),
    localparam int OUT_W     = $clog2(MAX_OUTSTD) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    glb_rdport_arb_if.master      bus,
    output logic                  ARB_Busy,
    output logic [IDX_W-1:0]      ARB_GntIdx,
    output logic                  ARB_Err
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       gnt_idx;
    logic [ADDR_WIDTH-1:0]  base;
    logic [LEN_WIDTH-1:0]   len;
    logic [LEN_WIDTH-1:0]   addr_cnt;
    logic [OUT_W-1:0]       outstd;
    logic                   err;

    logic                   pick_vld;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W:0]         cand;
    logic [ADDR_WIDTH-1:0]  pick_addr;
    logic [LEN_WIDTH-1:0]   pick_len;
    logic [NUM_REQ-1:0]     cmd_rdy;
    logic [NUM_REQ-1:0]     dat_vld;
    logic                   addr_vld;
    logic                   addr_hs;
    logic                   dat_rdy;
    logic                   dat_hs;
    logic                   outstd_nz;
    logic                   last_addr;
    logic                   drain_done;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ-1)) ? '0 : i + 1'b1;
    endfunction

    // Walk downward so the candidate closest to rr_ptr is the last to win.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (bus.REQARB_CmdVld[cand[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign pick_addr  = bus.REQARB_CmdAddr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign pick_len   = bus.REQARB_CmdLen[pick_idx*LEN_WIDTH +: LEN_WIDTH];

    assign outstd_nz  = (outstd != '0);
    assign addr_vld   = (state == ISSUE) && (outstd < OUT_W'(MAX_OUTSTD));
    assign addr_hs    = addr_vld && bus.GLBARB_RdAddrRdy;
    assign dat_rdy    = bus.REQARB_DatRdy[gnt_idx] && outstd_nz && (state != IDLE);
    assign dat_hs     = bus.GLBARB_RdDatVld && dat_rdy;
    assign last_addr  = (addr_cnt == len - LEN_WIDTH'(1));
    assign drain_done = !outstd_nz || ((outstd == OUT_W'(1)) && dat_hs);

    always_comb begin
        state_nxt = state;
        cmd_rdy   = '0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    cmd_rdy[pick_idx] = 1'b1;
                    if (pick_len != '0) begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (addr_hs && last_addr) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dat_vld          = '0;
        dat_vld[gnt_idx] = bus.GLBARB_RdDatVld && outstd_nz;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_idx  <= '0;
            base     <= '0;
            len      <= '0;
            addr_cnt <= '0;
            outstd   <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && pick_vld) begin
                gnt_idx  <= pick_idx;
                base     <= pick_addr;
                len      <= pick_len;
                addr_cnt <= '0;
                // A null burst never visits DRAIN, so advance the pointer here.
                if (pick_len == '0) begin
                    rr_ptr <= next_idx(pick_idx);
                end
            end
            if (addr_hs) begin
                addr_cnt <= addr_cnt + LEN_WIDTH'(1);
            end
            if ((state == DRAIN) && drain_done) begin
                rr_ptr <= next_idx(gnt_idx);
            end
            case ({addr_hs, dat_hs})
                2'b10:   outstd <= outstd + OUT_W'(1);
                2'b01:   outstd <= outstd - OUT_W'(1);
                default: outstd <= outstd;
            endcase
            if (bus.GLBARB_RdDatVld && (!outstd_nz || (state == IDLE))) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.ARBREQ_CmdRdy    = cmd_rdy;
    assign bus.ARBREQ_Dat       = bus.GLBARB_RdDat;
    assign bus.ARBREQ_DatVld    = dat_vld;
    assign bus.ARBGLB_RdAddrVld = addr_vld;
    assign bus.ARBGLB_RdAddr    = (state == ISSUE) ? base + ADDR_WIDTH'(addr_cnt) : '0;
    assign bus.ARBGLB_RdDatRdy  = dat_rdy;
    assign ARB_Busy             = (state != IDLE);
    assign ARB_GntIdx           = gnt_idx;
    assign ARB_Err              = err;

endmodule
